sampler_ctrl: RTL and testbench

SAMPLER_CTRL -- requirements
Module: sampler_ctrl

---
 rtl/sampler_ctrl.sv | 134 +++++++++++++
 tb/tb_sampler_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sampler_ctrl.sv
// rtl/sampler_ctrl.sv - start/stop sequencer for sampler register writes (optional SAMPLER_CTRL_AUTOSTOP_EN)
module sampler_ctrl #(
    parameter logic [4:0] DIV_ADDR  = 5'd4,
    parameter logic [4:0] CTRL_ADDR = 5'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic [31:0] cfg_div,
    input  logic [2:0]  cfg_mode,
    input  logic        overflow,
    input  logic        err_clr,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        wvalid,
    output logic        cmd_ack,
    output logic        running,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DIV,
        S_WR_ON,
        S_RUN,
        S_WR_OFF
    } state_t;

    state_t      r_state;
    logic [31:0] r_div;
    logic [2:0]  r_mode;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;
    logic        r_wvalid;
    logic        r_cmd_ack;
    logic        r_running;
    logic        r_busy;
    logic        r_err;
    logic        w_err_window;
    logic        w_leave_run;

    // overflow only matters once the sampler has been switched on
    assign w_err_window = (r_state == S_WR_ON) || (r_state == S_RUN) || (r_state == S_WR_OFF);

`ifdef SAMPLER_CTRL_AUTOSTOP_EN
    assign w_leave_run = cmd_stop || overflow;
`else
    assign w_leave_run = cmd_stop;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div     <= 32'd0;
            r_mode    <= 3'd0;
            r_waddr   <= 5'd0;
            r_wdata   <= 32'd0;
            r_wvalid  <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_running <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_waddr   <= 5'd0;
            r_wdata   <= 32'd0;
            r_wvalid  <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_running <= 1'b0;
            r_busy    <= 1'b0;

            if (overflow && w_err_window) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            // outputs are registered for the state being entered
            case (r_state)
                S_IDLE: begin
                    if (cmd_start) begin
                        r_div     <= cfg_div;
                        r_mode    <= cfg_mode;
                        r_cmd_ack <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_waddr   <= DIV_ADDR;
                        r_wdata   <= cfg_div;
                        r_busy    <= 1'b1;
                        r_state   <= S_WR_DIV;
                    end
                end
                S_WR_DIV: begin
                    r_wvalid <= 1'b1;
                    r_waddr  <= CTRL_ADDR;
                    r_wdata  <= {27'd0, r_mode, 1'b0, 1'b1};
                    r_busy   <= 1'b1;
                    r_state  <= S_WR_ON;
                end
                S_WR_ON: begin
                    r_running <= 1'b1;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    if (w_leave_run) begin
                        r_cmd_ack <= cmd_stop;
                        r_wvalid  <= 1'b1;
                        r_waddr   <= CTRL_ADDR;
                        r_wdata   <= {27'd0, r_mode, 1'b0, 1'b0};
                        r_busy    <= 1'b1;
                        r_state   <= S_WR_OFF;
                    end else begin
                        r_running <= 1'b1;
                    end
                end
                S_WR_OFF: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign waddr   = r_waddr;
    assign wdata   = r_wdata;
    assign wvalid  = r_wvalid;
    assign cmd_ack = r_cmd_ack;
    assign running = r_running;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule

// File: tb/tb_sampler_ctrl.sv
// tb/tb_sampler_ctrl.sv - self-checking bench for sampler_ctrl against a write-queue reference model
module tb_sampler_ctrl;

    localparam logic [4:0] DIV_ADDR  = 5'd4;
    localparam logic [4:0] CTRL_ADDR = 5'd0;
`ifdef SAMPLER_CTRL_AUTOSTOP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam logic [1:0] K_DIV = 2'd1, K_ON = 2'd2, K_OFF = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0, cmd_stop = 1'b0, overflow = 1'b0, err_clr = 1'b0;
    logic [31:0] cfg_div = 32'd0;
    logic [2:0]  cfg_mode = 3'd0;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wvalid, cmd_ack, running, busy, err;

    sampler_ctrl #(.DIV_ADDR(DIV_ADDR), .CTRL_ADDR(CTRL_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .overflow(overflow), .err_clr(err_clr),
        .waddr(waddr), .wdata(wdata), .wvalid(wvalid), .cmd_ack(cmd_ack),
        .running(running), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t      q[$];
    wr_t      cur;
    bit       cur_v, m_run, m_err, m_ack;
    bit [2:0] m_mode;

    function automatic logic [41:0] obs();
        return {cmd_ack, wvalid, waddr, wdata, running, busy, err};
    endfunction

    function automatic logic [41:0] expv();
        return {m_ack, cur_v, cur_v ? cur.addr : 5'd0, cur_v ? cur.data : 32'd0, m_run, cur_v, m_err};
    endfunction

    task automatic model_reset();
        q.delete();
        cur = '0; cur_v = 0; m_run = 0; m_err = 0; m_ack = 0; m_mode = 0;
    endtask

    // the model sees the sequence as a list of pending writes plus a "sampler on" flag
    task automatic model_edge();
        bit active;
        active = m_run || (cur_v && cur.kind != K_DIV);
        if (overflow && active) m_err = 1;
        else if (err_clr) m_err = 0;
        m_ack = 0;
        if (cur_v) begin
            if (cur.kind == K_ON) m_run = 1;
            if (q.size() > 0) cur = q.pop_front();
            else cur_v = 0;
        end else if (!m_run) begin
            if (cmd_start) begin
                m_ack = 1;
                m_mode = cfg_mode;
                cur.kind = K_DIV; cur.addr = DIV_ADDR; cur.data = cfg_div; cur_v = 1;
                q.push_back({K_ON, CTRL_ADDR, 32'(cfg_mode) * 4 + 32'd1});
            end
        end else if (cmd_stop || (AUTO && overflow)) begin
            m_ack = cmd_stop;
            m_run = 0;
            cur.kind = K_OFF; cur.addr = CTRL_ADDR; cur.data = 32'(m_mode) * 4; cur_v = 1;
        end
    endtask

    task automatic cycle(input bit st, input bit sp, input bit ov, input bit cl,
                         input logic [31:0] d, input logic [2:0] m);
        cmd_start = st; cmd_stop = sp; overflow = ov; err_clr = cl; cfg_div = d; cfg_mode = m;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle1();
        cycle(0, 0, 0, 0, 32'd0, 3'd0);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs() !== 42'd0) begin
            n_bad++; $display("FAIL reset_state got %h want %h", obs(), 42'd0);
        end
        rst_n = 1'b1;
        idle1();
        n_vec++;
        if (obs() !== expv()) begin
            n_bad++; $display("FAIL reset_idle got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_start();
        cycle(1, 0, 0, 0, 32'd2, 3'd3);
        n_vec++;
        if ({cmd_ack, wvalid, waddr, wdata} !== {1'b1, 1'b1, 5'd4, 32'd2} || obs() !== expv()) begin
            n_bad++; $display("FAIL start_wr_div got %h want ack,wv,4,2 / %h", obs(), expv());
        end
        idle1();
        n_vec++;
        if ({cmd_ack, wvalid, waddr, wdata, busy} !== {1'b0, 1'b1, 5'd0, 32'h0D, 1'b1} || obs() !== expv()) begin
            n_bad++; $display("FAIL start_wr_on got %h want 0,0x0D / %h", obs(), expv());
        end
        idle1();
        n_vec++;
        if ({running, busy, wvalid} !== 3'b100 || obs() !== expv()) begin
            n_bad++; $display("FAIL start_run got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_stop();
        cycle(0, 1, 0, 0, 32'd0, 3'd0);
        n_vec++;
        if ({cmd_ack, wvalid, waddr, wdata} !== {1'b1, 1'b1, 5'd0, 32'h0C} || obs() !== expv()) begin
            n_bad++; $display("FAIL stop_wr_off got %h want ack,0,0x0C / %h", obs(), expv());
        end
        idle1();
        n_vec++;
        if ({running, busy, wvalid, cmd_ack} !== 4'b0000 || obs() !== expv()) begin
            n_bad++; $display("FAIL stop_idle got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_ignored();
        cycle(0, 1, 0, 0, 32'd0, 3'd0);
        n_vec++;
        if ({cmd_ack, wvalid, busy} !== 3'b000 || obs() !== expv()) begin
            n_bad++; $display("FAIL stop_in_idle got %h want %h", obs(), expv());
        end
        cycle(1, 1, 0, 0, 32'd7, 3'd5);
        n_vec++;
        if ({cmd_ack, waddr, wdata} !== {1'b1, 5'd4, 32'd7} || obs() !== expv()) begin
            n_bad++; $display("FAIL both_in_idle got %h want %h", obs(), expv());
        end
        cycle(1, 0, 0, 0, 32'd99, 3'd1);
        n_vec++;
        if ({cmd_ack, wdata} !== {1'b0, 32'h15} || obs() !== expv()) begin
            n_bad++; $display("FAIL start_in_wr_div got %h want %h", obs(), expv());
        end
        idle1();
        cycle(1, 1, 0, 0, 32'd5, 3'd2);
        n_vec++;
        if ({cmd_ack, wdata} !== {1'b1, 32'h14} || obs() !== expv()) begin
            n_bad++; $display("FAIL both_in_run got %h want %h", obs(), expv());
        end
        idle1();
    endtask

    task automatic test_overflow();
        cycle(1, 0, 0, 0, 32'd9, 3'd6);
        idle1();
        idle1();
        cycle(0, 0, 1, 0, 32'd0, 3'd0);
        n_vec++;
        if (err !== 1'b1 || obs() !== expv()) begin
            n_bad++; $display("FAIL overflow_err got %h want %h", obs(), expv());
        end
        n_vec++;
        if (AUTO) begin
            if ({cmd_ack, wvalid, waddr, wdata, running} !== {1'b0, 1'b1, 5'd0, 32'h18, 1'b0}) begin
                n_bad++; $display("FAIL overflow_autostop got %h want wr 0,0x18 no ack", obs());
            end
            idle1();
        end else begin
            if ({running, wvalid, cmd_ack} !== 3'b100) begin
                n_bad++; $display("FAIL overflow_stays_run got %h want running", obs());
            end
            cycle(0, 1, 0, 0, 32'd0, 3'd0);
            idle1();
        end
        n_vec++;
        if ({running, busy, err} !== 3'b001 || obs() !== expv()) begin
            n_bad++; $display("FAIL overflow_after got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_err_clr();
        cycle(1, 0, 0, 1, 32'd3, 3'd1);
        n_vec++;
        if (err !== 1'b0 || cmd_ack !== 1'b1 || obs() !== expv()) begin
            n_bad++; $display("FAIL clr_on_start got %h want %h", obs(), expv());
        end
        idle1();
        idle1();
        cycle(0, 0, 1, 1, 32'd0, 3'd0);
        n_vec++;
        if (err !== 1'b1 || obs() !== expv()) begin
            n_bad++; $display("FAIL set_beats_clr got %h want %h", obs(), expv());
        end
        if (AUTO) idle1();
        cycle(0, 0, 0, 1, 32'd0, 3'd0);
        n_vec++;
        if (err !== 1'b0 || obs() !== expv()) begin
            n_bad++; $display("FAIL clr_alone got %h want %h", obs(), expv());
        end
        if (!AUTO) begin
            cycle(0, 1, 0, 0, 32'd0, 3'd0);
            idle1();
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, 0, 32'd11, 3'd4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (obs() !== 42'd0) begin
            n_bad++; $display("FAIL reset_async got %h want 0", obs());
        end
        cmd_start = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle1();
            n_vec++;
            if (wvalid !== 1'b0 || obs() !== expv()) begin
                n_bad++; $display("FAIL reset_no_write c%0d got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                  $urandom, 3'($urandom));
            n_vec++;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL random c%0d got %h want %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_stop();
        test_ignored();
        test_overflow();
        test_err_clr();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
